// File: rtl/fetch_stage_if.sv
// Instruction-memory request/done bus between the fetch stage and imem.
//   imem_addr   : fetch address (word-aligned PC)
//   imem_rd_en  : read request, held high until imem_done
//   imem_data   : returned instruction, valid when imem_done=1
//   imem_done   : response strobe
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    localparam int unsigned XLEN = 16;

    logic [XLEN-1:0] imem_addr;
    logic            imem_rd_en;
    logic [XLEN-1:0] imem_data;
    logic            imem_done;

    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_data,
        input  imem_done
    );

    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_data,
        output imem_done
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, fetches from a multi-cycle imem, applies execute redirects
// and hazard stalls, and freezes fetch after a HALT instruction.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   stall         : hold PC and IF/ID (a returning response goes to a hold buffer)
//   redirect      : taken branch/jump from execute, target on redirect_pc
//   imem          : fetch_stage_if.master request/done bus to instruction memory
//   instr_out     : IF/ID instruction to decode
//   pc_plus2_out  : IF/ID PC+2 of instr_out
//   valid_out     : instr_out is a real instruction (0 = bubble)
//   halted        : fetch frozen after HALT
//   err           : sticky misalignment flag
// Optional feature macro: FETCH_ALIGN_CHECK_EN enables the alignment checker
// driving err; without it err is tied low.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [15:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [15:0]          instr_out,
    output logic [15:0]          pc_plus2_out,
    output logic                 valid_out,
    output logic                 halted,
    output logic                 err
);
    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc2_q, pc2_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] buf_pc2_q, buf_pc2_d;
    logic            buf_v_q, buf_v_d;

    logic            rd_en_c;
    logic            accept_c;
    logic            is_halt_c;
    logic            outstanding_c;
    logic [XLEN-1:0] pc_inc_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pc2_q     <= '0;
            valid_q   <= 1'b0;
            buf_q     <= '0;
            buf_pc2_q <= '0;
            buf_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc2_q     <= pc2_d;
            valid_q   <= valid_d;
            buf_q     <= buf_d;
            buf_pc2_q <= buf_pc2_d;
            buf_v_q   <= buf_v_d;
        end
    end

    // Next-state: redirect > stall > normal
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc2_d     = pc2_q;
        valid_d   = valid_q;
        buf_d     = buf_q;
        buf_pc2_d = buf_pc2_q;
        buf_v_d   = buf_v_q;

        rd_en_c   = (state_q == FETCH) && !buf_v_q;
        accept_c  = rd_en_c && imem.imem_done;
        is_halt_c = (imem.imem_data[15:11] == HALT_OPC);
        pc_inc_c  = XLEN'(pc_q + XLEN'(2));
        // A redirect while already draining still owes memory one response.
        outstanding_c = (rd_en_c || (state_q == DRAIN)) && !imem.imem_done;

        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            buf_v_d = 1'b0;
            state_d = outstanding_c ? DRAIN : FETCH;
        end else begin
            if ((state_q == DRAIN) && imem.imem_done) begin
                state_d = FETCH;
            end

            if (stall) begin
                if (accept_c) begin
                    buf_d     = imem.imem_data;
                    buf_pc2_d = pc_inc_c;
                    buf_v_d   = 1'b1;
                    pc_d      = pc_inc_c;
                    if (is_halt_c) begin
                        state_d = HALTED;
                    end
                end
            end else if (buf_v_q) begin
                instr_d = buf_q;
                pc2_d   = buf_pc2_q;
                valid_d = 1'b1;
                buf_v_d = 1'b0;
            end else if (accept_c) begin
                instr_d = imem.imem_data;
                pc2_d   = pc_inc_c;
                valid_d = 1'b1;
                pc_d    = pc_inc_c;
                if (is_halt_c) begin
                    state_d = HALTED;
                end
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;

    // Sticky misalignment flag: odd redirect target or odd fetch address
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((redirect && redirect_pc[0]) || (pc_q[0] && rd_en_c)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign imem.imem_addr  = pc_q;
    assign imem.imem_rd_en = rd_en_c;
    assign instr_out       = instr_q;
    assign pc_plus2_out    = pc2_q;
    assign valid_out       = valid_q;
    assign halted          = (state_q == HALTED);

endmodule
